sample_window_ctrl: RTL
=======================

SAMPLE_WINDOW_CTRL -- requirements
Module: sample_window_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_SIZE, default 2048, samples per analysis window (power of two, >=4).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample width in bits.
REQ-003 SHALL have port clk_in  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sample_in  input  DATA_WIDTH  audio sample from the I2S front end.
REQ-006 SHALL have port sample_valid_in  input  1  one-cycle strobe, sample_in valid; back-to-back strobes legal.
REQ-007 SHALL have port bram_addr_out  output  log2(2*WINDOW_SIZE)  write address = {bank, index}.
REQ-008 SHALL have port bram_data_out  output  DATA_WIDTH  write data.
REQ-009 SHALL have port bram_we_out  output  1  write enable.
REQ-010 SHALL have port window_valid_out  output  1  level, a full window is presented to the consumer.
REQ-011 SHALL have port window_bank_out  output  1  bank holding the presented window.
REQ-012 SHALL have port window_done_in  input  1  consumer pulse releasing the presented bank.
REQ-013 SHALL have port overrun_count_out  output  16  dropped-sample count, saturating.

Function
REQ-014 SHALL manage two ping-pong banks, each FREE, FILLING or FULL; exactly one FILLING bank or writer in WAIT.
REQ-015 SHALL have writer FSM states FILL and WAIT, plus write bank wb and index idx (0..WINDOW_SIZE-1).
REQ-016 In FILL, a strobe accepted in cycle N SHALL drive bram_we_out=1, bram_addr_out={wb,idx}, bram_data_out=sample_in in cycle N+1 only; idx increments.
REQ-017 bram_we_out SHALL be 0 in every cycle not following an accepted strobe.
REQ-018 On accepting the strobe at idx=WINDOW_SIZE-1, SHALL mark wb FULL, wrap idx to 0, and switch wb to the other bank in FILL if that bank is FREE, else enter WAIT.
REQ-019 In WAIT, every strobe SHALL be dropped (no write) and overrun_count_out increments by 1, saturating at 16'hFFFF.
REQ-020 window_valid_out SHALL rise in cycle N+2 for a bank completed by a strobe accepted in cycle N, when no other window is presented.
REQ-021 FULL banks SHALL be presented oldest first; window_bank_out stable while window_valid_out=1.
REQ-022 window_done_in with window_valid_out=1 in cycle M SHALL free the presented bank; window_valid_out=0 in M+1; a pending FULL bank presented from M+2.
REQ-023 window_done_in while window_valid_out=0 SHALL be ignored.
REQ-024 A release in cycle M while in WAIT SHALL return the writer to FILL on the freed bank, idx=0; strobes from M+1 accepted, a strobe in cycle M dropped and counted.
REQ-025 Release in cycle M coinciding with acceptance of a bank-completing strobe SHALL switch wb to the freed bank with no WAIT and no drop.
REQ-026 Only FULL banks SHALL ever be presented; a FILLING bank is never presented.

Reset
REQ-027 While rst_in=1 in cycle R, outputs from R+1 SHALL be: bram_we_out=0, bram_addr_out=0, bram_data_out=0, window_valid_out=0, window_bank_out=0, overrun_count_out=0.
REQ-028 Reset SHALL place both banks FREE, writer in FILL, wb=0, idx=0, regardless of operation in progress; strobes during reset dropped and not counted.
REQ-029 The first strobe after reset deasserts SHALL be written to address 0.

Verification (WINDOW_SIZE=4)
REQ-030 Reset; strobes 0x0001..0x0004 spaced 5 cycles -> writes addr 0..3 with those data; window_valid_out=1, window_bank_out=0 two cycles after 4th strobe.
REQ-031 No done; strobes 0x0005..0x000A -> addr 4..7 written; last two dropped; overrun_count_out=2; window_bank_out stays 0.
REQ-032 Then done pulse -> window_valid_out low one cycle, then high with window_bank_out=1; next strobe 0x000B written to addr 0.
REQ-033 Done for bank 0 in the same cycle as 4th strobe into bank 1 -> next strobe to addr 0, overrun unchanged, bank 1 presented two cycles later.
REQ-034 Reset after 2 strobes into bank 1 with bank 0 presented -> all outputs zero; next strobe written to addr 0.
REQ-035 Continuous strobes in WAIT for 70000 cycles -> overrun_count_out holds 16'hFFFF.

Source files
------------

// File: rtl/sample_window_ctrl.sv
// Ping-pong capture of an audio sample stream into a two-bank BRAM, with windows
// handed to a consumer oldest first and dropped samples counted while both banks are busy.
module sample_window_ctrl #(
   parameter int unsigned WINDOW_SIZE = 2048,
   parameter int unsigned DATA_WIDTH  = 16
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic [DATA_WIDTH-1:0]                sample_in,
   input  logic                                 sample_valid_in,
   output logic [$clog2(2*WINDOW_SIZE)-1:0]     bram_addr_out,
   output logic [DATA_WIDTH-1:0]                bram_data_out,
   output logic                                 bram_we_out,
   output logic                                 window_valid_out,
   output logic                                 window_bank_out,
   input  logic                                 window_done_in,
   output logic [15:0]                          overrun_count_out
);

   localparam int unsigned ADDR_W = $clog2(2*WINDOW_SIZE);
   localparam int unsigned IDX_W  = ADDR_W - 1;

   typedef enum logic {ST_FILL, ST_WAIT} wr_state_t;
   typedef enum logic [1:0] {BK_FREE, BK_FILLING, BK_FULL} bank_state_t;

   wr_state_t        state_q, state_d;
   logic             wb_q, wb_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   bank_state_t      bank_q [2];
   bank_state_t      bank_d [2];
   logic             next_pres_q, next_pres_d;

   logic                  we_d, valid_d, wbank_d;
   logic [ADDR_W-1:0]     addr_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic [15:0]           ovr_d;

   logic accept, release_win, last_idx, other_free;

   assign accept      = sample_valid_in && (state_q == ST_FILL);
   assign release_win = window_done_in && window_valid_out;
   assign last_idx    = (idx_q == IDX_W'(WINDOW_SIZE - 1));
   // The bank being released this cycle counts as free for an immediate switch.
   assign other_free  = (bank_q[~wb_q] == BK_FREE) ||
                        (release_win && (window_bank_out == ~wb_q));

   // State and output registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q           <= ST_FILL;
         wb_q              <= 1'b0;
         idx_q             <= '0;
         bank_q[0]         <= BK_FREE;
         bank_q[1]         <= BK_FREE;
         next_pres_q       <= 1'b0;
         bram_we_out       <= 1'b0;
         bram_addr_out     <= '0;
         bram_data_out     <= '0;
         window_valid_out  <= 1'b0;
         window_bank_out   <= 1'b0;
         overrun_count_out <= '0;
      end else begin
         state_q           <= state_d;
         wb_q              <= wb_d;
         idx_q             <= idx_d;
         bank_q            <= bank_d;
         next_pres_q       <= next_pres_d;
         bram_we_out       <= we_d;
         bram_addr_out     <= addr_d;
         bram_data_out     <= data_d;
         window_valid_out  <= valid_d;
         window_bank_out   <= wbank_d;
         overrun_count_out <= ovr_d;
      end
   end

   // Writer next state and bank bookkeeping.
   always_comb begin
      state_d = state_q;
      wb_d    = wb_q;
      idx_d   = idx_q;
      bank_d  = bank_q;

      if (release_win) bank_d[window_bank_out] = BK_FREE;

      if (accept) begin
         if (last_idx) begin
            bank_d[wb_q] = BK_FULL;
            idx_d        = '0;
            if (other_free) begin
               wb_d          = ~wb_q;
               bank_d[~wb_q] = BK_FILLING;
            end else begin
               state_d = ST_WAIT;
            end
         end else begin
            bank_d[wb_q] = BK_FILLING;
            idx_d        = idx_q + IDX_W'(1);
         end
      end else if (state_q == ST_WAIT && release_win) begin
         state_d                 = ST_FILL;
         wb_d                    = window_bank_out;
         idx_d                   = '0;
         bank_d[window_bank_out] = BK_FILLING;
      end
   end

   // Next values of the registered outputs.
   always_comb begin
      we_d        = accept;
      addr_d      = bram_addr_out;
      data_d      = bram_data_out;
      valid_d     = window_valid_out;
      wbank_d     = window_bank_out;
      next_pres_d = next_pres_q;
      ovr_d       = overrun_count_out;

      if (accept) begin
         addr_d = {wb_q, idx_q};
         data_d = sample_in;
      end

      if (state_q == ST_WAIT && sample_valid_in && overrun_count_out != 16'hFFFF)
         ovr_d = overrun_count_out + 16'd1;

      // Banks complete in alternation, so a toggling pointer yields oldest-first order.
      if (release_win) begin
         valid_d = 1'b0;
      end else if (!window_valid_out && bank_q[next_pres_q] == BK_FULL) begin
         valid_d     = 1'b1;
         wbank_d     = next_pres_q;
         next_pres_d = ~next_pres_q;
      end
   end

endmodule
